// File: rtl/lfsr_pkg.sv
// Shared LFSR types, next-state formula and maximal tap table.
// Used by lfsr_step, lfsr_gen and the later multi-step variant.
package lfsr_pkg;

   typedef enum logic {FIBO, GALOIS} lfsr_mode_e;

   // Galois-form (right shift) maximal masks, indexed by width
   localparam logic [31:0] MAX_TAPS [3:32] = '{
      32'h0000_0006, 32'h0000_000C, 32'h0000_0014, 32'h0000_0030,
      32'h0000_0060, 32'h0000_00B8, 32'h0000_0110, 32'h0000_0240,
      32'h0000_0500, 32'h0000_0829, 32'h0000_100D, 32'h0000_2015,
      32'h0000_6000, 32'h0000_D008, 32'h0001_2000, 32'h0002_0400,
      32'h0004_0023, 32'h0009_0000, 32'h0014_0000, 32'h0030_0000,
      32'h0042_0000, 32'h00E1_0000, 32'h0120_0000, 32'h0200_0023,
      32'h0400_0013, 32'h0900_0000, 32'h1400_0000, 32'h2000_0029,
      32'h4800_0000, 32'h8020_0003
   };

   function automatic logic [31:0] lfsr_next(
      input lfsr_mode_e  mode,
      input int unsigned width,
      input logic [31:0] taps,
      input logic [31:0] r
   );
      logic        fb;
      logic [31:0] sh;
      sh = r >> 1;
      fb = ^(r & taps);
      if (mode == FIBO)
         return sh | (32'(fb) << (width - 1));
      return sh ^ ({32{r[0]}} & taps);
   endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single LFSR step, r -> r_next.
// Kept separate so a multi-step variant can chain copies.
module lfsr_step
   import lfsr_pkg::*;
#(
   parameter int              WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS = 4'b0011,
   parameter lfsr_mode_e      MODE  = FIBO
) (
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] r_next
);

   assign r_next = WIDTH'(lfsr_next(MODE, WIDTH, 32'(TAPS), 32'(r)));

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator with seed load, step enable, zero-seed lockup
// recovery, period wrap pulse and saturating step counter.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH = 4,
   parameter logic [WIDTH-1:0] TAPS  = 4'b0011,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
   parameter lfsr_mode_e       MODE  = FIBO
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] q,
   output logic             bit_out,
   output logic             wrap,
   output logic [WIDTH-1:0] steps,
   output logic             lockup
);

   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be 3..32");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: SEED must be non-zero");
   end

   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] r_next;
   logic [WIDTH-1:0] seed_reg;

   lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
   ) u_step (
      .r      (r),
      .r_next (r_next)
   );

   // A zero seed would lock the register, so SEED replaces it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r        <= SEED;
         seed_reg <= SEED;
         steps    <= '0;
         wrap     <= 1'b0;
         lockup   <= 1'b0;
      end else begin
         wrap   <= 1'b0;
         lockup <= 1'b0;
         if (load) begin
            steps <= '0;
            if (seed_in != '0) begin
               r        <= seed_in;
               seed_reg <= seed_in;
            end else begin
               r        <= SEED;
               seed_reg <= SEED;
               lockup   <= 1'b1;
            end
         end else if (en) begin
            r <= r_next;
            if (r_next == seed_reg) begin
               wrap  <= 1'b1;
               steps <= '0;
            end else if (steps != '1) begin
               steps <= steps + WIDTH'(1);
            end
         end
      end
   end

   assign q       = r;
   assign bit_out = r[0];

endmodule
